pc_ctrl: RTL and testbench

Parametrised program-counter controller for the RV32I core, the successor to the basic PC register. It generates the fetch address and presents it to instruction memory over a valid/ready handshake. It applies prioritised redirects (trap, mret, branch/jump) and holds a saved exception PC. After reset it waits a programmable boot delay before the first fetch.

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/pc_ctrl_if.sv | 27 ++
 rtl/pc_ctrl.sv | 127 ++++++++++++
 tb/tb_pc_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared constants and FSM encoding for the RV32I program-counter controller.
// Build option: PC_MISALIGN_TRAP_EN (see pc_ctrl.sv).
package pc_ctrl_pkg;

  localparam int unsigned PC_XLEN        = 32;
  localparam int unsigned PC_CNT_W       = 16;
  localparam int unsigned PC_STEP_DEF    = 4;
  localparam int unsigned PC_BOOT_DELAY  = 2;
  localparam logic [31:0] PC_BOOT_ADDR   = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC    = 32'h0000_0010;

  typedef enum logic [0:0] {
    PC_ST_BOOT = 1'b0,
    PC_ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch request channel between the PC controller and instruction memory.
interface pc_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN
);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_plus_step;

  modport master (
    output fetch_valid,
    output fetch_pc,
    output pc_plus_step,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    input  pc_plus_step,
    output fetch_ready
  );

endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: boot delay, sequential fetch, prioritised redirects, saved EPC.
// Build option PC_MISALIGN_TRAP_EN: misaligned redirect/mret targets trap and pulse misalign_err.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN       = PC_XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDR  = XLEN'(PC_BOOT_ADDR),
  parameter int unsigned     PC_STEP    = PC_STEP_DEF,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PC_TRAP_VEC),
  parameter int unsigned     BOOT_DELAY = PC_BOOT_DELAY,
  parameter int unsigned     CNT_W      = PC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_req,
  input  logic             mret_req,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] fetch_count,
`ifdef PC_MISALIGN_TRAP_EN
  output logic             misalign_err,
`endif
  pc_ctrl_if.master        fetch_if
);

  localparam int unsigned     BOOT_W    = $clog2(BOOT_DELAY + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY - 1);
  localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(PC_STEP - 1);
  localparam logic [XLEN-1:0] STEP      = XLEN'(PC_STEP);

  pc_state_e        state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fetch_valid_c;
  logic             accept;
  logic [XLEN-1:0]  tgt;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misalign_q, misalign_d;
`endif

  assign fetch_valid_c = (state_q == PC_ST_RUN) && !stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= BOOT_ADDR;
      epc_q      <= '0;
      count_q    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state: boot countdown, then trap > mret > redirect > sequential step
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    count_d    = count_q;
    accept     = 1'b0;
    tgt        = mret_req ? epc_q : redirect_target;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      PC_ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = PC_ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      PC_ST_RUN: begin
        accept = fetch_valid_c && fetch_if.fetch_ready;
        if (accept) begin
          count_d = count_q + CNT_W'(1);
        end
        if (trap_req) begin
          epc_d = pc_q;
          pc_d  = TRAP_VEC;
        end else if (mret_req || redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
          if ((tgt & LOW_MASK) != '0) begin
            epc_d      = pc_q;
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
`else
          pc_d = tgt & ~LOW_MASK;
`endif
        end else if (accept) begin
          pc_d = pc_q + STEP;
        end
      end
      default: state_d = PC_ST_BOOT;
    endcase
  end

  assign fetch_if.fetch_valid  = fetch_valid_c;
  assign fetch_if.fetch_pc     = pc_q;
  assign fetch_if.pc_plus_step = pc_q + STEP;
  assign epc                   = epc_q;
  assign fetch_count           = count_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_err          = misalign_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_pc_ctrl;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned BOOT_DELAY = 2;
  localparam int unsigned CNT_W      = 16;
  localparam logic [31:0] BOOT_ADDR  = 32'h0;
  localparam logic [31:0] TRAP_VEC   = 32'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        mret_req;
  logic [31:0] epc;
  logic [15:0] fetch_count;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  int          m_boot;
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [15:0] m_cnt;
  bit          m_mis;

  pc_ctrl_if #(.XLEN(XLEN)) fif ();

  pc_ctrl #(
    .XLEN(XLEN), .BOOT_ADDR(BOOT_ADDR), .PC_STEP(PC_STEP),
    .TRAP_VEC(TRAP_VEC), .BOOT_DELAY(BOOT_DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_req(trap_req),
    .mret_req(mret_req),
    .epc(epc),
    .fetch_count(fetch_count),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .fetch_if(fif)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_boot = 0; m_run = 0; m_pc = BOOT_ADDR; m_epc = 32'h0; m_cnt = 16'h0; m_mis = 0;
  endtask

  // Advance model by one edge using the inputs currently driven, then clock the DUT.
  task automatic cycle();
    logic [31:0] t;
    bit acc;
    m_mis = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      m_boot++;
      if (m_boot >= BOOT_DELAY) m_run = 1;
    end else begin
      acc = !stall && fif.fetch_ready;
      if (acc) m_cnt = m_cnt + 16'd1;
      if (trap_req) begin
        m_epc = m_pc; m_pc = TRAP_VEC;
      end else if (mret_req || redirect_valid) begin
        t = mret_req ? m_epc : redirect_target;
        if (t % PC_STEP != 0) begin
`ifdef PC_MISALIGN_TRAP_EN
          m_epc = m_pc; m_pc = TRAP_VEC; m_mis = 1;
`else
          m_pc = t - (t % PC_STEP);
`endif
        end else begin
          m_pc = t;
        end
      end else if (acc) begin
        m_pc = m_pc + PC_STEP;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_target = 32'h0; trap_req = 0; mret_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); fif.fetch_ready = 1;
    model_reset();
    cycle();
    tests++; if (fif.fetch_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", fif.fetch_pc); end
    tests++; if (epc !== 32'h0) begin fails++; $display("FAIL reset_epc got %h want 0", epc); end
    tests++; if (fetch_count !== 16'h0) begin fails++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    tests++; if (fif.fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", fif.fetch_valid); end
    rst_n = 1;
  endtask

  task automatic test_boot_seq();
    for (int i = 0; i < 2; i++) begin
      tests++; if (fif.fetch_valid !== 1'b0) begin fails++; $display("FAIL boot_valid%0d got %b want 0", i, fif.fetch_valid); end
      cycle();
    end
    tests++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 32'h0) begin
      fails++; $display("FAIL boot_first got v=%b pc=%h want v=1 pc=0", fif.fetch_valid, fif.fetch_pc); end
    cycle();
    tests++; if (fif.fetch_pc !== 32'h4 || fetch_count !== 16'd1) begin
      fails++; $display("FAIL seq1 got pc=%h cnt=%0d want 4/1", fif.fetch_pc, fetch_count); end
    tests++; if (fif.pc_plus_step !== 32'h8) begin fails++; $display("FAIL plus_step got %h want 8", fif.pc_plus_step); end
    cycle();
    tests++; if (fif.fetch_pc !== 32'h8 || fetch_count !== 16'd2) begin
      fails++; $display("FAIL seq2 got pc=%h cnt=%0d want 8/2", fif.fetch_pc, fetch_count); end
  endtask

  task automatic test_ready_hold();
    fif.fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++; if (fif.fetch_pc !== 32'h8 || fetch_count !== 16'd2 || fif.fetch_valid !== 1'b1) begin
        fails++; $display("FAIL hold%0d got pc=%h cnt=%0d v=%b want 8/2/1", i, fif.fetch_pc, fetch_count, fif.fetch_valid); end
    end
    fif.fetch_ready = 1;
    cycle();
    tests++; if (fif.fetch_pc !== 32'hC || fetch_count !== 16'd3) begin
      fails++; $display("FAIL hold_release got pc=%h cnt=%0d want c/3", fif.fetch_pc, fetch_count); end
  endtask

  task automatic test_trap_priority();
    fif.fetch_ready = 0;
    redirect_valid = 1; redirect_target = 32'h20;
    cycle();
    tests++; if (fif.fetch_pc !== 32'h20) begin fails++; $display("FAIL redir20 got %h want 20", fif.fetch_pc); end
    trap_req = 1; mret_req = 1; redirect_valid = 1; redirect_target = 32'h100;
    cycle();
    tests++; if (fif.fetch_pc !== 32'h10 || epc !== 32'h20) begin
      fails++; $display("FAIL trap_prio got pc=%h epc=%h want 10/20", fif.fetch_pc, epc); end
    idle_inputs(); mret_req = 1;
    cycle();
    tests++; if (fif.fetch_pc !== 32'h20 || fetch_count !== 16'd3) begin
      fails++; $display("FAIL mret got pc=%h cnt=%0d want 20/3", fif.fetch_pc, fetch_count); end
    idle_inputs();
  endtask

  task automatic test_stall_redirect();
    fif.fetch_ready = 1; stall = 1; redirect_valid = 1; redirect_target = 32'h40;
    cycle();
    redirect_valid = 0;
    tests++; if (fif.fetch_valid !== 1'b0 || fif.fetch_pc !== 32'h40 || fetch_count !== 16'd3) begin
      fails++; $display("FAIL stall_redir got v=%b pc=%h cnt=%0d want 0/40/3", fif.fetch_valid, fif.fetch_pc, fetch_count); end
    cycle();
    tests++; if (fif.fetch_pc !== 32'h40) begin fails++; $display("FAIL stall_hold got %h want 40", fif.fetch_pc); end
    stall = 0;
    #1;
    tests++; if (fif.fetch_valid !== 1'b1) begin fails++; $display("FAIL unstall_valid got %b want 1", fif.fetch_valid); end
    cycle();
    tests++; if (fif.fetch_pc !== 32'h44 || fetch_count !== 16'd4) begin
      fails++; $display("FAIL unstall_step got pc=%h cnt=%0d want 44/4", fif.fetch_pc, fetch_count); end
  endtask

  task automatic test_misalign();
    fif.fetch_ready = 0; redirect_valid = 1; redirect_target = 32'h102;
    cycle();
    redirect_valid = 0;
`ifdef PC_MISALIGN_TRAP_EN
    tests++; if (fif.fetch_pc !== 32'h10 || epc !== 32'h44 || misalign_err !== 1'b1) begin
      fails++; $display("FAIL misalign_trap got pc=%h epc=%h err=%b want 10/44/1", fif.fetch_pc, epc, misalign_err); end
    cycle();
    tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL misalign_pulse got %b want 0", misalign_err); end
`else
    tests++; if (fif.fetch_pc !== 32'h100) begin fails++; $display("FAIL misalign_mask got %h want 100", fif.fetch_pc); end
`endif
  endtask

  task automatic test_async_reset();
    fif.fetch_ready = 1; redirect_valid = 1; redirect_target = 32'h44;
    cycle();
    redirect_valid = 0; fif.fetch_ready = 0;
    tests++; if (fif.fetch_pc !== 32'h44 || fetch_count !== 16'd5) begin
      fails++; $display("FAIL pre_reset got pc=%h cnt=%0d want 44/5", fif.fetch_pc, fetch_count); end
    fif.fetch_ready = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    tests++; if (fif.fetch_pc !== 32'h0 || epc !== 32'h0 || fetch_count !== 16'h0 || fif.fetch_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset got pc=%h epc=%h cnt=%0d v=%b want 0/0/0/0", fif.fetch_pc, epc, fetch_count, fif.fetch_valid); end
    cycle();
    rst_n = 1;
    cycle();
    tests++; if (fif.fetch_valid !== 1'b0) begin fails++; $display("FAIL reboot_wait got %b want 0", fif.fetch_valid); end
    cycle();
    tests++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 32'h0) begin
      fails++; $display("FAIL reboot got v=%b pc=%h want 1/0", fif.fetch_valid, fif.fetch_pc); end
    cycle();
    tests++; if (fif.fetch_pc !== 32'h4 || fetch_count !== 16'd1) begin
      fails++; $display("FAIL reboot_step got pc=%h cnt=%0d want 4/1", fif.fetch_pc, fetch_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stall           = ($urandom_range(3) == 0);
      fif.fetch_ready = ($urandom_range(3) != 0);
      trap_req        = ($urandom_range(15) == 0);
      mret_req        = ($urandom_range(15) == 0);
      redirect_valid  = ($urandom_range(7) == 0);
      redirect_target = $urandom();
      if ($urandom_range(1) == 0) redirect_target[1:0] = 2'b00;
      if (i == 300) redirect_target = 32'hFFFF_FFFC;
      cycle();
      idle_inputs();
      #1;
      tests++;
      if (fif.fetch_pc !== m_pc || epc !== m_epc || fetch_count !== m_cnt ||
          fif.fetch_valid !== 1'(m_run) || fif.pc_plus_step !== m_pc + PC_STEP) begin
        fails++;
        $display("FAIL rand%0d got pc=%h epc=%h cnt=%0d v=%b ps=%h want pc=%h epc=%h cnt=%0d v=%b",
                 i, fif.fetch_pc, epc, fetch_count, fif.fetch_valid, fif.pc_plus_step,
                 m_pc, m_epc, m_cnt, m_run);
      end
`ifdef PC_MISALIGN_TRAP_EN
      tests++;
      if (misalign_err !== 1'(m_mis)) begin
        fails++; $display("FAIL rand_mis%0d got %b want %b", i, misalign_err, m_mis);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_ready_hold();
    test_trap_priority();
    test_stall_redirect();
    test_misalign();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
